qq_arbiter: RTL

Round-robin arbiter and sequencer that shares one QuickQ priority queue among N requesters. Each requester posts a level-held enqueue or dequeue request. The arbiter selects one requester, checks full/empty, and issues a single-cycle enq/deq pulse to the queue. It then waits for the queue to return ready and acknowledges the requester, returning dequeued data where applicable. It sits between client logic and the queue's enq_i/deq_i/rdy/full/empty/data-out pins.

---
 rtl/qq_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/qq_arbiter.sv
// Round-robin arbiter/sequencer sharing one QuickQ priority queue among N requesters.
// Define QQ_ARB_TIMEOUT_EN to bound the WAIT state to TO cycles and enable the sticky timeout flag.
module qq_arbiter #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int TO = 16
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic [N-1:0]   i_req_enq,
    input  logic [N-1:0]   i_req_deq,
    input  logic [N*W-1:0] i_req_data,
    output logic [N-1:0]   o_ack,
    output logic           o_err,
    output logic [W-1:0]   o_deq_data,
    output logic           o_deq_valid,
    output logic           o_timeout,
    output logic           o_q_enq,
    output logic           o_q_deq,
    output logic [W-1:0]   o_q_din,
    input  logic           i_q_rdy,
    input  logic           i_q_full,
    input  logic           i_q_empty,
    input  logic [W-1:0]   i_q_dout
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t         r_state, w_state_nxt;
    logic [PW-1:0]  r_ptr, r_gnt, w_gnt, w_ptr_nxt;
    logic           r_deq_op, r_err;
    logic [W-1:0]   r_key, r_dout, w_key;
    logic [N-1:0]   w_pend;
    logic           w_found, w_grant, w_g_enq, w_g_deq, w_bad, w_to_hit;

    assign w_pend = i_req_enq | i_req_deq;

    // First pending requester at or after the pointer, wrapping modulo N.
    always_comb begin
        logic [PW-1:0] v_idx;
        v_idx   = '0;
        w_found = 1'b0;
        w_gnt   = '0;
        for (int k = 0; k < N; k++) begin
            v_idx = PW'((int'(r_ptr) + k) % N);
            if (!w_found && w_pend[v_idx]) begin
                w_found = 1'b1;
                w_gnt   = v_idx;
            end
        end
    end

    always_comb begin
        w_key = '0;
        for (int k = 0; k < N; k++) begin
            if (w_gnt == PW'(k))
                w_key = i_req_data[k*W +: W];
        end
    end

    assign w_ptr_nxt = PW'((int'(w_gnt) + 1) % N);
    assign w_grant   = (r_state == S_IDLE) && w_found && i_q_rdy;
    assign w_g_enq   = i_req_enq[w_gnt];
    assign w_g_deq   = i_req_deq[w_gnt];
    // Rejected requests skip the queue entirely and are acked with err.
    assign w_bad     = (w_g_enq && w_g_deq) || (w_g_enq && i_q_full) || (w_g_deq && i_q_empty);

`ifdef QQ_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TO + 1);
    logic [CW-1:0] r_wcnt;
    logic          r_timeout;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_to_hit    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_grant)
                    w_state_nxt = w_bad ? S_DONE : S_ISSUE;
            end
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (i_q_rdy)
                    w_state_nxt = S_DONE;
`ifdef QQ_ARB_TIMEOUT_EN
                else if (r_wcnt == CW'(TO - 1)) begin
                    w_state_nxt = S_DONE;
                    w_to_hit    = 1'b1;
                end
`endif
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr    <= '0;
            r_gnt    <= '0;
            r_deq_op <= 1'b0;
            r_err    <= 1'b0;
            r_key    <= '0;
            r_dout   <= '0;
        end else begin
            if (w_grant) begin
                r_gnt    <= w_gnt;
                r_deq_op <= w_g_deq;
                r_key    <= w_key;
                r_ptr    <= w_ptr_nxt;
                r_err    <= w_bad;
            end
            if (r_state == S_WAIT && i_q_rdy && r_deq_op)
                r_dout <= i_q_dout;
            if (w_to_hit)
                r_err <= 1'b1;
        end
    end

`ifdef QQ_ARB_TIMEOUT_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wcnt    <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (r_state != S_WAIT) r_wcnt <= '0;
            else                   r_wcnt <= r_wcnt + 1'b1;
            if (w_to_hit)
                r_timeout <= 1'b1;
        end
    end
    assign o_timeout = r_timeout;
`else
    assign o_timeout = 1'b0;
`endif

    assign o_q_enq     = (r_state == S_ISSUE) && !r_deq_op;
    assign o_q_deq     = (r_state == S_ISSUE) && r_deq_op;
    assign o_q_din     = r_key;
    assign o_ack       = (r_state == S_DONE) ? ({{(N-1){1'b0}}, 1'b1} << r_gnt) : '0;
    assign o_err       = (r_state == S_DONE) && r_err;
    assign o_deq_valid = (r_state == S_DONE) && r_deq_op && !r_err;
    assign o_deq_data  = r_dout;

endmodule
